// File: rtl/usb_pkg.sv
// Shared USB TX types: packet encoding, PIDs, SYNC byte,
// CRC16 constants and small decode helpers.
package usb_pkg;

  typedef enum logic [2:0] {
    PKT_DATA0 = 3'd1,
    PKT_DATA1 = 3'd2,
    PKT_ACK   = 3'd3,
    PKT_NAK   = 3'd4,
    PKT_STALL = 3'd5
  } tx_packet_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_FETCH,
    S_LOAD,
    S_DATA,
    S_CRC_LO,
    S_CRC_HI,
    S_DONE
  } tx_state_t;

  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam logic [7:0]  SYNC_BYTE = 8'h80;
  localparam logic [15:0] CRC_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC_POLY  = 16'hA001;
  localparam logic [6:0]  MAX_LEN   = 7'd64;

  function automatic logic is_legal(
    input logic [2:0] t
  );
    return (t >= 3'd1) && (t <= 3'd5);
  endfunction

  function automatic logic is_data(
    input logic [2:0] t
  );
    return (t == PKT_DATA0) || (t == PKT_DATA1);
  endfunction

  // PID byte on the wire is {~pid, pid}.
  function automatic logic [7:0] pid_byte(
    input logic [2:0] t
  );
    logic [3:0] p;
    case (t)
      PKT_DATA0: p = PID_DATA0;
      PKT_DATA1: p = PID_DATA1;
      PKT_ACK:   p = PID_ACK;
      PKT_NAK:   p = PID_NAK;
      PKT_STALL: p = PID_STALL;
      default:   p = 4'h0;
    endcase
    return {~p, p};
  endfunction

endpackage

// File: rtl/usb_tx_packet_ctrl_if.sv
// Byte stream from packet controller to bit serializer.
// master: drives byte_out/byte_valid/byte_last; slave: drives byte_ready.
interface usb_tx_packet_ctrl_if;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_last;

  modport master (
    output byte_out,
    output byte_valid,
    output byte_last,
    input  byte_ready
  );

  modport slave (
    input  byte_out,
    input  byte_valid,
    input  byte_last,
    output byte_ready
  );
endinterface

// File: rtl/usb_crc16.sv
// Byte-wide USB CRC16 (reflected 0xA001, LSB first).
// Ports: clk, n_rst, clear, enable, data[7:0] in; crc[15:0] out.
module usb_crc16
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  always_comb begin
    crc_d = crc_q ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      crc_d = crc_d[0] ? ((crc_d >> 1) ^ CRC_POLY)
                       : (crc_d >> 1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc_q <= CRC_INIT;
    end else if (clear) begin
      crc_q <= CRC_INIT;
    end else if (enable) begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_tx_packet_ctrl.sv
// USB TX packet controller: SYNC, PID, FIFO payload, optional CRC16.
// Ports: clk, n_rst; tx_start/tx_packet/buffer_occupancy request;
// tx_packet_data/get_tx_packet_data FIFO; ser byte stream (master);
// tx_busy/tx_done/tx_error status. CRC appended when TX_CRC_GEN_EN defined.
module usb_tx_packet_ctrl
  import usb_pkg::*;
(
  input  logic                clk,
  input  logic                n_rst,
  input  logic                tx_start,
  input  logic [2:0]          tx_packet,
  input  logic [6:0]          buffer_occupancy,
  input  logic [7:0]          tx_packet_data,
  output logic                get_tx_packet_data,
  usb_tx_packet_ctrl_if.master ser,
  output logic                tx_busy,
  output logic                tx_done,
  output logic                tx_error
);

  tx_state_t  state_q;
  logic [2:0] type_q;
  logic [6:0] len_q;
  logic [7:0] byte_q;
  logic       valid_q;
  logic       last_q;
  logic       get_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;

  logic       xfer;
  logic       start_ok;

  assign xfer     = valid_q & ser.byte_ready;
  assign start_ok = tx_start & is_legal(tx_packet)
                  & (buffer_occupancy <= MAX_LEN);

`ifdef TX_CRC_GEN_EN
  logic [15:0] crc;
  logic        crc_clr;
  logic        crc_en;

  assign crc_clr = (state_q == S_IDLE) & start_ok;
  assign crc_en  = (state_q == S_DATA) & xfer;

  usb_crc16 u_crc (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (crc_clr),
    .enable (crc_en),
    .data   (byte_q),
    .crc    (crc)
  );
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      type_q  <= 3'd0;
      len_q   <= 7'd0;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      get_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      get_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (tx_start) begin
            if (start_ok) begin
              type_q  <= tx_packet;
              len_q   <= is_data(tx_packet)
                       ? buffer_occupancy : 7'd0;
              byte_q  <= SYNC_BYTE;
              valid_q <= 1'b1;
              last_q  <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= S_SYNC;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_SYNC: begin
          if (xfer) begin
            byte_q  <= pid_byte(type_q);
`ifdef TX_CRC_GEN_EN
            last_q  <= !is_data(type_q);
`else
            last_q  <= !is_data(type_q)
                    || (len_q == 7'd0);
`endif
            state_q <= S_PID;
          end
        end
        S_PID: begin
          if (xfer) begin
            if (!is_data(type_q)) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (len_q != 7'd0) begin
              valid_q <= 1'b0;
              get_q   <= 1'b1;
              state_q <= S_FETCH;
            end else begin
`ifdef TX_CRC_GEN_EN
              valid_q <= 1'b0;
              state_q <= S_CRC_LO;
`else
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
`endif
            end
          end
        end
        S_FETCH: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          byte_q  <= tx_packet_data;
          valid_q <= 1'b1;
`ifndef TX_CRC_GEN_EN
          last_q  <= (len_q == 7'd1);
`endif
          state_q <= S_DATA;
        end
        S_DATA: begin
          if (xfer) begin
            len_q   <= len_q - 7'd1;
            valid_q <= 1'b0;
            if (len_q == 7'd1) begin
`ifdef TX_CRC_GEN_EN
              state_q <= S_CRC_LO;
`else
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
`endif
            end else begin
              get_q   <= 1'b1;
              state_q <= S_FETCH;
            end
          end
        end
`ifdef TX_CRC_GEN_EN
        // One bubble cycle lets the last data byte
        // settle into the CRC register before it is shown.
        S_CRC_LO: begin
          if (!valid_q) begin
            byte_q  <= ~crc[7:0];
            valid_q <= 1'b1;
          end else if (ser.byte_ready) begin
            byte_q  <= ~crc[15:8];
            last_q  <= 1'b1;
            state_q <= S_CRC_HI;
          end
        end
        S_CRC_HI: begin
          if (xfer) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          busy_q  <= 1'b0;
          type_q  <= 3'd0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign get_tx_packet_data = get_q;
  assign ser.byte_out       = byte_q;
  assign ser.byte_valid     = valid_q;
  assign ser.byte_last      = last_q;
  assign tx_busy            = busy_q;
  assign tx_done            = done_q;
  assign tx_error           = err_q;

endmodule

// File: tb/tb_usb_tx_packet_ctrl.sv
// Randomized scoreboard bench for usb_tx_packet_ctrl.
// Expected bytes come from a packet-level model of SYNC/PID/payload/CRC.
module tb_usb_tx_packet_ctrl;

`ifdef TX_CRC_GEN_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [2:0] tx_packet = 3'd0;
  logic [6:0] buffer_occupancy = 7'd0;
  logic [7:0] tx_packet_data = 8'h00;
  logic       get_tx_packet_data;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  usb_tx_packet_ctrl_if bus ();

  usb_tx_packet_ctrl dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_start           (tx_start),
    .tx_packet          (tx_packet),
    .buffer_occupancy   (buffer_occupancy),
    .tx_packet_data     (tx_packet_data),
    .get_tx_packet_data (get_tx_packet_data),
    .ser                (bus),
    .tx_busy            (tx_busy),
    .tx_done            (tx_done),
    .tx_error           (tx_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       last;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] fifo[$];
  int checks = 0;
  int errors = 0;
  int pops = 0;
  int xfers = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int exp_pops = 0;
  int exp_total = 0;
  bit rand_ready = 1'b0;
  bit pop_pend = 1'b0;
  logic [7:0] pend_data = 8'h00;
  bit stall = 1'b0;
  logic [7:0] held_b = 8'h00;
  logic held_last = 1'b0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] pid_of(input logic [2:0] t);
    case (t)
      3'd1: return 8'hC3;
      3'd2: return 8'h4B;
      3'd3: return 8'hD2;
      3'd4: return 8'h5A;
      default: return 8'h1E;
    endcase
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] c,
                                           input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if ((r[0] ^ d[k]) == 1'b1) r = (r >> 1) ^ 16'hA001;
      else r = r >> 1;
    end
    return r;
  endfunction

  initial begin
    bus.byte_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.byte_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pop_pend) begin
        tx_packet_data = pend_data;
        pop_pend = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!n_rst) begin
      stall = 1'b0;
    end else begin
      if (get_tx_packet_data) begin
        pops++;
        if (fifo.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fifo_underflow actual pop required none");
        end else begin
          pend_data = fifo.pop_front();
          pop_pend = 1'b1;
        end
      end
      if (tx_done) done_cnt++;
      if (tx_error) err_cnt++;
      if (stall) begin
        check("hold_valid", 32'(bus.byte_valid), 32'd1);
        check("hold_byte", 32'(bus.byte_out), 32'(held_b));
        check("hold_last", 32'(bus.byte_last), 32'(held_last));
      end
      if (bus.byte_valid && bus.byte_ready) begin
        xfers++;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte actual %0h required none",
                   bus.byte_out);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("byte_out", 32'(bus.byte_out), 32'(e.b));
          check("byte_last", 32'(bus.byte_last), 32'(e.last));
        end
      end
      stall = bus.byte_valid && !bus.byte_ready;
      held_b = bus.byte_out;
      held_last = bus.byte_last;
    end
  end

  task automatic start_pkt(input logic [2:0] t, input int occ,
                           input bit ramp);
    logic [15:0] c;
    logic [7:0]  d;
    int          n;
    bit          dat;
    fifo.delete();
    expq.delete();
    pops = 0;
    xfers = 0;
    done_cnt = 0;
    dat = (t == 3'd1) || (t == 3'd2);
    n = dat ? occ : 0;
    c = 16'hFFFF;
    for (int i = 0; i < occ; i++) begin
      d = ramp ? 8'(i + 1) : 8'($urandom);
      fifo.push_back(d);
    end
    expq.push_back('{8'h80, 1'b0});
    expq.push_back('{pid_of(t), !dat || (!CRC_ON && n == 0)});
    for (int i = 0; i < n; i++) begin
      d = fifo[i];
      expq.push_back('{d, !CRC_ON && (i == n - 1)});
      c = crc_step(c, d);
    end
    if (CRC_ON) begin
      c = ~c;
      expq.push_back('{c[7:0], 1'b0});
      expq.push_back('{c[15:8], 1'b1});
    end
    exp_total = expq.size();
    exp_pops = n;
    @(posedge clk);
    #1;
    tx_start = 1'b1;
    tx_packet = t;
    buffer_occupancy = 7'(occ);
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    tx_packet = 3'($urandom);
    buffer_occupancy = 7'($urandom_range(0, 64));
    @(negedge clk);
    check("busy_set", 32'(tx_busy), 32'd1);
  endtask

  task automatic wait_done(input string nm);
    for (int c = 0; c < 3000 && done_cnt == 0; c++) @(negedge clk);
    check({nm, "_done"}, 32'(done_cnt), 32'd1);
    @(negedge clk);
    check({nm, "_busy_clr"}, 32'(tx_busy), 32'd0);
    check({nm, "_done_pulse"}, 32'(done_cnt), 32'd1);
    check({nm, "_pops"}, 32'(pops), 32'(exp_pops));
    check({nm, "_bytes"}, 32'(xfers), 32'(exp_total));
    check({nm, "_sb_empty"}, 32'(expq.size()), 32'd0);
  endtask

  task automatic bad_req(input logic [2:0] t, input int occ);
    err_cnt = 0;
    pops = 0;
    xfers = 0;
    @(posedge clk);
    #1;
    tx_start = 1'b1;
    tx_packet = t;
    buffer_occupancy = 7'(occ);
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    @(negedge clk);
    check("err_pulse", 32'(tx_error), 32'd1);
    check("err_busy", 32'(tx_busy), 32'd0);
    check("err_valid", 32'(bus.byte_valid), 32'd0);
    repeat (4) @(negedge clk);
    check("err_single", 32'(err_cnt), 32'd1);
    check("err_busy_later", 32'(tx_busy), 32'd0);
    check("err_no_bytes", 32'(xfers), 32'd0);
    check("err_no_pops", 32'(pops), 32'd0);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_get"}, 32'(get_tx_packet_data), 32'd0);
    check({nm, "_byte"}, 32'(bus.byte_out), 32'd0);
    check({nm, "_valid"}, 32'(bus.byte_valid), 32'd0);
    check({nm, "_last"}, 32'(bus.byte_last), 32'd0);
    check({nm, "_busy"}, 32'(tx_busy), 32'd0);
    check({nm, "_done"}, 32'(tx_done), 32'd0);
    check({nm, "_err"}, 32'(tx_error), 32'd0);
  endtask

  initial begin
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (2) @(posedge clk);

    rand_ready = 1'b0;
    start_pkt(3'd3, 5, 1'b0);
    wait_done("ack");

    start_pkt(3'd1, 0, 1'b0);
    wait_done("data0_empty");

    start_pkt(3'd2, 17, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    tx_start = 1'b1;
    tx_packet = 3'd3;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    wait_done("data1_17");

    rand_ready = 1'b1;
    start_pkt(3'd1, 64, 1'b0);
    wait_done("data0_64");

    bad_req(3'd7, 10);
    bad_req(3'd0, 0);
    bad_req(3'd1, 65);

    rand_ready = 1'b0;
    start_pkt(3'd1, 20, 1'b0);
    for (int c = 0; c < 500 && xfers < 5; c++) @(negedge clk);
    check("rst_progress", 32'(xfers >= 5), 32'd1);
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    expq.delete();
    fifo.delete();
    pop_pend = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    start_pkt(3'd3, 0, 1'b0);
    wait_done("ack_after_rst");

    for (int k = 0; k < 6; k++) begin
      rand_ready = 1'($urandom_range(0, 1));
      start_pkt(3'($urandom_range(1, 5)), $urandom_range(0, 64), 1'b0);
      wait_done("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
